serial_tx4: RTL and testbench



---
 rtl/serial_tx4.sv | 131 +++++++++++++
 tb/tb_serial_tx4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx4.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Each bit is held for BIT_CYCLES clocks. tx/busy/done are driven directly from flops.
module serial_tx4 #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BI_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cc;
  logic [BW-1:0]    r_bi;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state;
  logic [WIDTH-1:0] w_sr;
  logic [CW-1:0]    w_cc;
  logic [BW-1:0]    w_bi;
  logic             w_tx;
  logic             w_busy;
  logic             w_done;
  logic             w_cc_last;

  assign w_cc_last = (r_cc == CC_LAST);

  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_cc    = r_cc;
    w_bi    = r_bi;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_sr    = d;
          w_cc    = '0;
          w_state = S_START;
        end
      end
      S_START: begin
        if (w_cc_last) begin
          w_cc    = '0;
          w_bi    = '0;
          w_state = S_DATA;
        end else begin
          w_cc = r_cc + 1'b1;
        end
      end
      S_DATA: begin
        if (w_cc_last) begin
          w_sr = r_sr >> 1;
          w_cc = '0;
          if (r_bi == BI_LAST) begin
            w_state = S_STOP;
          end else begin
            w_bi = r_bi + 1'b1;
          end
        end else begin
          w_cc = r_cc + 1'b1;
        end
      end
      S_STOP: begin
        if (w_cc_last) begin
          w_cc    = '0;
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_cc = r_cc + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes on the same edge as the state.
  always_comb begin
    w_tx = 1'b1;
    case (w_state)
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = w_sr[0];
      default: w_tx = 1'b1;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cc    <= '0;
      r_bi    <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sr    <= w_sr;
      r_cc    <= w_cc;
      r_bi    <= w_bi;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_tx4.sv
// Directed self-checking bench for serial_tx4: default timing plus a BIT_CYCLES=1 instance.
module tb_serial_tx4;

  logic       clk;
  logic       reset;
  logic [3:0] d;
  logic       load;
  logic       tx;
  logic       busy;
  logic       done;

  logic [3:0] d1;
  logic       load1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int total;
  int bad;

  serial_tx4 #(.WIDTH(4), .BIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .load  (load),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  serial_tx4 #(.WIDTH(4), .BIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .load  (load1),
    .tx    (tx1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with load=1 already driven. pat[k] is the expected line level in bit-time k.
  task automatic frame(input string tag, input logic [5:0] pat, input int poke,
                       input logic [3:0] nd, input logic hold);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("%s_tx_c%0d", tag, i), tx, pat[i/2]);
      chk($sformatf("%s_busy_c%0d", tag, i), busy, 1'b1);
      chk($sformatf("%s_done_c%0d", tag, i), done, 1'b0);
      load = hold;
      if (i == poke) begin
        d    = nd;
        load = 1'b1;
      end
    end
    @(negedge clk);
    chk($sformatf("%s_idle_tx", tag), tx, 1'b1);
    chk($sformatf("%s_idle_busy", tag), busy, 1'b0);
    chk($sformatf("%s_idle_done", tag), done, 1'b1);
  endtask

  initial begin
    logic [5:0] pat1;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    load  = 1'b0;
    d     = 4'b0000;
    load1 = 1'b0;
    d1    = 4'b0000;

    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("quiet_tx_c%0d", i), tx, 1'b1);
      chk($sformatf("quiet_busy_c%0d", i), busy, 1'b0);
      chk($sformatf("quiet_done_c%0d", i), done, 1'b0);
    end

    // d=0001: bit-times 0,1,0,0,0,1
    d    = 4'b0001;
    load = 1'b1;
    frame("f0001", 6'b100010, -1, 4'b0000, 1'b0);
    @(negedge clk);
    chk("f0001_after_done", done, 1'b0);
    chk("f0001_after_busy", busy, 1'b0);

    // d=1000, d changed and load pulsed at frame cycle 5: still 0,0,0,0,1,1
    d    = 4'b1000;
    load = 1'b1;
    frame("f1000", 6'b110000, 5, 4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("f1000_nodone_c%0d", i), done, 1'b0);
      chk($sformatf("f1000_nobusy_c%0d", i), busy, 1'b0);
      chk($sformatf("f1000_notx_c%0d", i), tx, 1'b1);
    end

    // load held high with d=0010: back-to-back frames, 0,0,1,0,0,1
    d    = 4'b0010;
    load = 1'b1;
    frame("hold_a", 6'b100100, -1, 4'b0000, 1'b1);
    frame("hold_b", 6'b100100, -1, 4'b0000, 1'b1);
    load = 1'b0;
    @(negedge clk);
    chk("hold_end_busy", busy, 1'b0);
    chk("hold_end_done", done, 1'b0);
    chk("hold_end_tx", tx, 1'b1);

    // Async reset during data bit 1 (frame cycles 4-5); d=1101 puts 0 on the line there
    d    = 4'b1101;
    load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
    chk("ar_pre_tx", tx, 1'b0);
    chk("ar_pre_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("ar_now_tx", tx, 1'b1);
    chk("ar_now_busy", busy, 1'b0);
    chk("ar_now_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("ar_post_tx_c%0d", i), tx, 1'b1);
      chk($sformatf("ar_post_busy_c%0d", i), busy, 1'b0);
      chk($sformatf("ar_post_done_c%0d", i), done, 1'b0);
    end

    // BIT_CYCLES=1, d=1010: 0,0,1,0,1,1 on consecutive cycles
    pat1  = 6'b110100;
    d1    = 4'b1010;
    load1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load1 = 1'b0;
      chk($sformatf("bc1_tx_c%0d", i), tx1, pat1[i]);
      chk($sformatf("bc1_busy_c%0d", i), busy1, 1'b1);
      chk($sformatf("bc1_done_c%0d", i), done1, 1'b0);
    end
    @(negedge clk);
    chk("bc1_idle_busy", busy1, 1'b0);
    chk("bc1_idle_done", done1, 1'b1);
    chk("bc1_idle_tx", tx1, 1'b1);
    @(negedge clk);
    chk("bc1_after_done", done1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
